// File: rtl/kd_tree_pkg.sv
// Shared definitions for the kd-tree node sorting blocks: FSM encodings,
// key mode constants, slot identifiers and width derivation helpers.
package kd_tree_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_DONE = 3'd4
    } kd_state_e;

    // Input slot a center originally came from, used for switch flags.
    typedef enum logic [1:0] {
        SLOT_L = 2'd0,
        SLOT_P = 2'd1,
        SLOT_R = 2'd2
    } kd_slot_e;

    localparam int MODE_AXIS = 0;
    localparam int MODE_FULL = 1;

    // Axis index width; never narrower than one bit, even for DIM=1.
    function automatic int calc_axw(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    // Packed center width.
    function automatic int calc_cw(input int dim, input int dw);
        return dim * dw;
    endfunction

endpackage

// File: rtl/kd_cmp_swap.sv
// Combinational compare-and-swap of two packed centers. The pair is put in
// ascending key order; equal keys keep their original order.
module kd_cmp_swap
    import kd_tree_pkg::*;
#(
    parameter int DIM  = 3,
    parameter int DW   = 8,
    parameter int MODE = MODE_AXIS,
    localparam int CW  = calc_cw(DIM, DW),
    localparam int AXW = calc_axw(DIM)
) (
    input  logic [CW-1:0]  a_in,
    input  logic [CW-1:0]  b_in,
    input  logic [AXW-1:0] axis,
    output logic [CW-1:0]  lo_out,
    output logic [CW-1:0]  hi_out,
    output logic           swap
);

    logic [DW-1:0] coord_a;
    logic [DW-1:0] coord_b;
    logic [CW-1:0] key_a;
    logic [CW-1:0] key_b;

    // Build the comparison keys: one coordinate, or the whole packed vector.
    always_comb begin
        coord_a = a_in[DW-1:0];
        coord_b = b_in[DW-1:0];
        for (int i = 1; i < DIM; i++) begin
            if (axis == AXW'(i)) begin
                coord_a = a_in[i*DW +: DW];
                coord_b = b_in[i*DW +: DW];
            end
        end
        if (MODE == MODE_FULL) begin
            key_a = a_in;
            key_b = b_in;
        end else begin
            key_a = CW'(coord_a);
            key_b = CW'(coord_b);
        end
    end

    // Strict greater-than, so ties never reorder.
    always_comb begin
        swap   = (key_a > key_b);
        lo_out = swap ? b_in : a_in;
        hi_out = swap ? a_in : b_in;
    end

endmodule

// File: rtl/kd_sort_ce.sv
// Three-center sorting engine for kd-tree construction. Accepts a
// (left, parent, right) triplet, orders it by key with a three-step
// compare-exchange network sharing one comparator, and reports the child
// split axis, which slots moved, and a saturating swap count.
module kd_sort_ce
    import kd_tree_pkg::*;
#(
    parameter int DIM   = 3,
    parameter int DW    = 8,
    parameter int MODE  = MODE_AXIS,
    parameter int CNT_W = 16,
    localparam int CW   = calc_cw(DIM, DW),
    localparam int AXW  = calc_axw(DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sort_en,
    input  logic [CW-1:0]    left_in,
    input  logic [CW-1:0]    parent_in,
    input  logic [CW-1:0]    right_in,
    input  logic [AXW-1:0]   axis_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    left_out,
    output logic [CW-1:0]    parent_out,
    output logic [CW-1:0]    right_out,
    output logic [AXW-1:0]   child_axis,
    output logic             stable,
    output logic             left_switch,
    output logic             parent_switch,
    output logic             right_switch,
    output logic [CNT_W-1:0] swap_count
);

    // Out-of-range axis values fall back to axis 0.
    function automatic logic [AXW-1:0] sanitize_axis(input logic [AXW-1:0] ax);
        if (int'(ax) >= DIM) return '0;
        return ax;
    endfunction

    // Round-robin split axis for the next tree level.
    function automatic logic [AXW-1:0] next_axis(input logic [AXW-1:0] ax);
        if (int'(ax) + 1 >= DIM) return '0;
        return ax + AXW'(1);
    endfunction

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    kd_state_e        state_q, state_d;
    logic [CW-1:0]    l_q, l_d, p_q, p_d, r_q, r_d;
    kd_slot_e         org_l_q, org_l_d, org_p_q, org_p_d, org_r_q, org_r_d;
    logic [AXW-1:0]   axis_q, axis_d;
    logic             swapped_q, swapped_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    lo_q, lo_d, po_q, po_d, ro_q, ro_d;
    logic [AXW-1:0]   child_q, child_d;
    logic             stable_q, stable_d;
    logic             lsw_q, lsw_d, psw_q, psw_d, rsw_q, rsw_d;

    logic [CW-1:0]    cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic             cmp_swap;

    // Steer the working pair of the current step into the shared comparator.
    always_comb begin
        cmp_a = l_q;
        cmp_b = p_q;
        if (state_q == ST_S1) begin
            cmp_a = p_q;
            cmp_b = r_q;
        end
    end

    kd_cmp_swap #(
        .DIM  (DIM),
        .DW   (DW),
        .MODE (MODE)
    ) u_cmp (
        .a_in   (cmp_a),
        .b_in   (cmp_b),
        .axis   (axis_q),
        .lo_out (cmp_lo),
        .hi_out (cmp_hi),
        .swap   (cmp_swap)
    );

    // Sequencing, working-set update and result capture.
    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        p_d       = p_q;
        r_d       = r_q;
        org_l_d   = org_l_q;
        org_p_d   = org_p_q;
        org_r_d   = org_r_q;
        axis_d    = axis_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        po_d      = po_q;
        ro_d      = ro_q;
        child_d   = child_q;
        stable_d  = stable_q;
        lsw_d     = lsw_q;
        psw_d     = psw_q;
        rsw_d     = rsw_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d       = left_in;
                    p_d       = parent_in;
                    r_d       = right_in;
                    org_l_d   = SLOT_L;
                    org_p_d   = SLOT_P;
                    org_r_d   = SLOT_R;
                    axis_d    = sanitize_axis(axis_in);
                    swapped_d = 1'b0;
                    if (sort_en) begin
                        state_d = ST_S0;
                    end else begin
                        // Pass-through publishes the triplet untouched.
                        state_d  = ST_DONE;
                        lo_d     = left_in;
                        po_d     = parent_in;
                        ro_d     = right_in;
                        child_d  = next_axis(sanitize_axis(axis_in));
                        stable_d = 1'b1;
                        lsw_d    = 1'b0;
                        psw_d    = 1'b0;
                        rsw_d    = 1'b0;
                    end
                end
            end
            ST_S0, ST_S2: begin
                if (cmp_swap) begin
                    l_d       = cmp_lo;
                    p_d       = cmp_hi;
                    org_l_d   = org_p_q;
                    org_p_d   = org_l_q;
                    swapped_d = 1'b1;
                    cnt_d     = sat_inc(cnt_q);
                end
                state_d = (state_q == ST_S0) ? ST_S1 : ST_DONE;
            end
            ST_S1: begin
                if (cmp_swap) begin
                    p_d       = cmp_lo;
                    r_d       = cmp_hi;
                    org_p_d   = org_r_q;
                    org_r_d   = org_p_q;
                    swapped_d = 1'b1;
                    cnt_d     = sat_inc(cnt_q);
                end
                state_d = ST_S2;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The last exchange step publishes the finished ordering.
        if (state_q == ST_S2) begin
            lo_d     = l_d;
            po_d     = p_d;
            ro_d     = r_d;
            child_d  = next_axis(axis_q);
            stable_d = ~swapped_d;
            lsw_d    = (org_l_d != SLOT_L);
            psw_d    = (org_p_d != SLOT_P);
            rsw_d    = (org_r_d != SLOT_R);
        end
    end

    // State and data registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            l_q       <= '0;
            p_q       <= '0;
            r_q       <= '0;
            org_l_q   <= SLOT_L;
            org_p_q   <= SLOT_P;
            org_r_q   <= SLOT_R;
            axis_q    <= '0;
            swapped_q <= 1'b0;
            cnt_q     <= '0;
            lo_q      <= '0;
            po_q      <= '0;
            ro_q      <= '0;
            child_q   <= '0;
            stable_q  <= 1'b0;
            lsw_q     <= 1'b0;
            psw_q     <= 1'b0;
            rsw_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            p_q       <= p_d;
            r_q       <= r_d;
            org_l_q   <= org_l_d;
            org_p_q   <= org_p_d;
            org_r_q   <= org_r_d;
            axis_q    <= axis_d;
            swapped_q <= swapped_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            po_q      <= po_d;
            ro_q      <= ro_d;
            child_q   <= child_d;
            stable_q  <= stable_d;
            lsw_q     <= lsw_d;
            psw_q     <= psw_d;
            rsw_q     <= rsw_d;
        end
    end

    assign left_out      = lo_q;
    assign parent_out    = po_q;
    assign right_out     = ro_q;
    assign child_axis    = child_q;
    assign stable        = stable_q;
    assign left_switch   = lsw_q;
    assign parent_switch = psw_q;
    assign right_switch  = rsw_q;
    assign swap_count    = cnt_q;

endmodule

// File: tb/tb_kd_sort_ce.sv
// Bench for kd_sort_ce: a default instance (MODE 0, 16-bit counter) and a
// MODE 1 instance with a 2-bit counter share stimulus; sel picks which one
// sees the handshake and whose outputs are checked.
module tb_kd_sort_ce;

    typedef struct {
        bit          d;      // 0: default instance, 1: MODE 1 / CNT_W 2
        bit          se;
        logic [1:0]  ax;
        logic [23:0] l, p, r;
        int          o0, o1, o2;  // input slot expected in each output slot
        int          nsw;         // swaps this triplet must cost
        logic [1:0]  ch;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, sort_en, out_ready, sel;
    logic [23:0] left_in, parent_in, right_in;
    logic [1:0]  axis_in;

    logic        d_in_ready, d_out_valid, d_stable, d_ls, d_ps, d_rs;
    logic [23:0] d_l, d_p, d_r;
    logic [1:0]  d_ch;
    logic [15:0] d_cnt;
    logic        m_in_ready, m_out_valid, m_stable, m_ls, m_ps, m_rs;
    logic [23:0] m_l, m_p, m_r;
    logic [1:0]  m_ch;
    logic [1:0]  m_cnt;

    logic        c_in_ready, c_out_valid, c_stable, c_ls, c_ps, c_rs;
    logic [23:0] c_l, c_p, c_r;
    logic [1:0]  c_ch;
    logic [15:0] c_cnt;

    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_cnt [2];
    vec_t tbl [$];
    vec_t sb [$];

    always #5 clk = ~clk;

    kd_sort_ce dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(d_in_ready), .sort_en(sort_en),
        .left_in(left_in), .parent_in(parent_in), .right_in(right_in), .axis_in(axis_in),
        .out_valid(d_out_valid), .out_ready(out_ready & ~sel),
        .left_out(d_l), .parent_out(d_p), .right_out(d_r), .child_axis(d_ch),
        .stable(d_stable), .left_switch(d_ls), .parent_switch(d_ps), .right_switch(d_rs),
        .swap_count(d_cnt)
    );

    kd_sort_ce #(.DIM(3), .DW(8), .MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(m_in_ready), .sort_en(sort_en),
        .left_in(left_in), .parent_in(parent_in), .right_in(right_in), .axis_in(axis_in),
        .out_valid(m_out_valid), .out_ready(out_ready & sel),
        .left_out(m_l), .parent_out(m_p), .right_out(m_r), .child_axis(m_ch),
        .stable(m_stable), .left_switch(m_ls), .parent_switch(m_ps), .right_switch(m_rs),
        .swap_count(m_cnt)
    );

    always_comb begin
        c_in_ready  = sel ? m_in_ready  : d_in_ready;
        c_out_valid = sel ? m_out_valid : d_out_valid;
        c_l         = sel ? m_l : d_l;
        c_p         = sel ? m_p : d_p;
        c_r         = sel ? m_r : d_r;
        c_ch        = sel ? m_ch : d_ch;
        c_stable    = sel ? m_stable : d_stable;
        c_ls        = sel ? m_ls : d_ls;
        c_ps        = sel ? m_ps : d_ps;
        c_rs        = sel ? m_rs : d_rs;
        c_cnt       = sel ? {14'd0, m_cnt} : d_cnt;
    end

    function automatic logic [23:0] c3(input int x, input int y, input int z);
        return {8'(z), 8'(y), 8'(x)};
    endfunction

    function automatic vec_t mk(input bit d, input bit se, input logic [1:0] ax,
                                input logic [23:0] l, input logic [23:0] p, input logic [23:0] r,
                                input int o0, input int o1, input int o2,
                                input int nsw, input logic [1:0] ch);
        vec_t v;
        v.d = d; v.se = se; v.ax = ax; v.l = l; v.p = p; v.r = r;
        v.o0 = o0; v.o1 = o1; v.o2 = o2; v.nsw = nsw; v.ch = ch;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        else
            n_pass++;
    endtask

    task automatic chk_out(input vec_t e);
        logic [23:0] ins [3];
        ins[0] = e.l; ins[1] = e.p; ins[2] = e.r;
        chk("left_out",      c_l, ins[e.o0]);
        chk("parent_out",    c_p, ins[e.o1]);
        chk("right_out",     c_r, ins[e.o2]);
        chk("child_axis",    c_ch, e.ch);
        chk("stable",        c_stable, (e.nsw == 0));
        chk("left_switch",   c_ls, (e.o0 != 0));
        chk("parent_switch", c_ps, (e.o1 != 1));
        chk("right_switch",  c_rs, (e.o2 != 2));
        chk("swap_count",    c_cnt, exp_cnt[int'(e.d)]);
    endtask

    // Drive one triplet, wait for its result, optionally stall the output
    // for 'hold' cycles (with a stray in_valid), then complete the handshake.
    task automatic run(input vec_t v, input int hold);
        vec_t e;
        int   lat;
        int   maxc;
        sel = v.d;
        left_in = v.l; parent_in = v.p; right_in = v.r;
        axis_in = v.ax; sort_en = v.se; in_valid = 1'b1;
        #1;
        chk("in_ready_idle", c_in_ready, 1);
        sb.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid", c_out_valid, 1);
        chk("latency", lat, v.se ? 4 : 1);
        e = sb.pop_front();
        maxc = e.d ? 3 : 65535;
        exp_cnt[int'(e.d)] = (exp_cnt[int'(e.d)] + e.nsw > maxc) ? maxc : exp_cnt[int'(e.d)] + e.nsw;
        chk_out(e);
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                left_in = 24'hABCDEF; parent_in = 24'h010203; right_in = 24'h7F7F7F;
                sort_en = 1'b1; in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            chk("hold_in_ready", c_in_ready, 0);
            chk("hold_out_valid", c_out_valid, 1);
            chk_out(e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_in_ready", c_in_ready, 1);
        chk("post_hs_out_valid", c_out_valid, 0);
        if (hold > 0) begin
            repeat (4) @(negedge clk);
            chk("stray_ignored", c_out_valid, 0);
            chk_out(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic seen;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        rst = 1'b0; in_valid = 1'b0; sort_en = 1'b0; out_ready = 1'b0; sel = 1'b0;
        left_in = '0; parent_in = '0; right_in = '0; axis_in = '0;

        // Default instance, MODE 0.
        tbl.push_back(mk(0, 1, 0, c3(9,0,0),   c3(5,0,0), c3(1,0,0),   2, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 2, c3(0,0,3),   c3(1,1,7), c3(2,2,7),   0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, c3(9,0,0),   c3(5,0,0), c3(1,0,0),   0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 1, 3, c3(3,9,0),   c3(2,0,0), c3(1,5,0),   2, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, c3(0,5,1),   c3(7,2,7), c3(3,8,4),   1, 0, 2, 1, 2));
        tbl.push_back(mk(0, 1, 0, c3(4,1,0),   c3(4,2,0), c3(1,3,0),   2, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, c3(0,3,0),   c3(0,9,0), c3(0,6,0),   0, 2, 1, 1, 2));
        tbl.push_back(mk(0, 1, 2, c3(1,0,5),   c3(2,0,5), c3(3,0,5),   0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, c3(255,1,1), c3(0,2,2), c3(255,3,3), 1, 0, 2, 1, 1));
        tbl.push_back(mk(0, 0, 3, c3(7,7,7),   c3(1,2,3), c3(4,5,6),   0, 1, 2, 0, 1));
        // MODE 1 instance with 2-bit saturating counter.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 1, 0, c3(9,0,0), c3(5,0,0), c3(1,0,0), 2, 1, 0, 3, 1));
        tbl.push_back(mk(1, 1, 0, c3(0,0,2),   c3(0,0,1), c3(0,0,3),   1, 0, 2, 1, 1));
        tbl.push_back(mk(1, 1, 2, c3(5,0,1),   c3(9,0,0), c3(0,0,2),   1, 0, 2, 1, 0));

        repeat (3) @(negedge clk);
        chk("rst_in_ready", d_in_ready, 1);
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_left_out", d_l, 0);
        chk("rst_swap_count", d_cnt, 0);
        chk("rst_swap_count_m", {14'd0, m_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i], 0);

        // Backpressure: result held for five cycles, stray input ignored.
        run(tbl[0], 5);

        // Reset while the default instance is in S1.
        sel = 1'b0;
        left_in = c3(9,0,0); parent_in = c3(5,0,0); right_in = c3(1,0,0);
        axis_in = 2'd0; sort_en = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        chk("midop_in_ready", d_in_ready, 1);
        chk("midop_out_valid", d_out_valid, 0);
        chk("midop_left", d_l, 0);
        chk("midop_parent", d_p, 0);
        chk("midop_right", d_r, 0);
        chk("midop_child", d_ch, 0);
        chk("midop_flags", {d_stable, d_ls, d_ps, d_rs}, 0);
        chk("midop_swap_count", d_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | d_out_valid;
        end
        chk("midop_no_pulse", seen, 0);

        // Normal operation resumes from a cleared counter.
        run(tbl[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kd_sort_ce.md
KD_SORT_CE -- requirements
Module: kd_sort_ce

Interface
REQ-001 Parameter DIM, default 3: coordinates per center (>=1).
REQ-002 Parameter DW, default 8: bits per coordinate, unsigned.
REQ-003 Parameter MODE, default 0: 0 = compare on the selected axis coordinate; 1 = compare the whole packed vector as one unsigned number.
REQ-004 Parameter CNT_W, default 16: swap-counter width.
REQ-005 Derived constants: CW = DIM*DW; AXW = max(1, clog2(DIM)); coordinate i occupies bits [i*DW +: DW].
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  input triplet valid.
REQ-009 in_ready  out  1  block can accept a triplet.
REQ-010 sort_en  in  1  sampled at accept; 0 = pass-through.
REQ-011 left_in / parent_in / right_in  in  CW each  node centers.
REQ-012 axis_in  in  AXW  split axis of the parent node.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 left_out / parent_out / right_out  out  CW each  sorted centers.
REQ-016 child_axis  out  AXW  axis for the child level.
REQ-017 stable  out  1  no swap occurred.
REQ-018 left_switch / parent_switch / right_switch  out  1 each  the slot's output came from a different input slot.
REQ-019 swap_count  out  CNT_W  total swaps since reset, saturating.

Function
REQ-020 FSM states: IDLE, S0, S1, S2, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-021 IDLE with in_valid=1: capture the three centers and axis; go to S0 if sort_en=1, else go to DONE with the data unchanged.
REQ-022 Each step is one edge, and each step swaps its pair only if key(first) > key(second), strictly:
- S0 compares (L,P) and goes to S1.
- S1 compares (P,R) and goes to S2.
- S2 compares (L,P) and goes to DONE.
REQ-023 Latency: out_valid rises 4 edges after the accept edge when sorting, and 1 edge after it in pass-through.
REQ-024 Keys: in MODE 0 the key is coordinate[axis]; in MODE 1 the key is the full CW-bit vector.
REQ-025 An axis_in value >= DIM is treated as axis 0 for keying and for child_axis.
REQ-026 child_axis = (axis+1 == DIM) ? 0 : axis+1; for DIM=1 it is always 0.
REQ-027 Equal keys never swap, so the sort is stable and preserves input order on ties.
REQ-028 Switch flags come from origin tracking, not from value compare; stable = no swap in S0..S2; in pass-through stable=1 and all switch flags are 0.
REQ-029 swap_count increments by 1 per actual swap, holds at all-ones, and never wraps.
REQ-030 In DONE, all outputs are held stable while out_ready=0; out_valid&&out_ready returns the FSM to IDLE on that edge.
REQ-031 in_valid is ignored outside IDLE, so there is no accept in the same cycle as output completion.
REQ-032 Output data registers are retained after DONE until the next result.

Reset
REQ-033 rst low, asynchronously at any state, returns the FSM to IDLE and clears all of the following: data outputs, child_axis, stable, switch flags and swap_count.
REQ-034 After reset, in_ready=1 and out_valid=0; an operation in flight is discarded without output.

Structure
REQ-035 The shared package kd_tree_pkg holds:
- FSM state encodings;
- MODE constants (MODE_AXIS=0, MODE_FULL=1);
- the AXW/CW derivation helpers.
REQ-036 One combinational sub-module, kd_cmp_swap, takes two centers, axis and MODE, and returns the ordered pair plus a swap flag; a single instance is reused across S0..S2 through pair muxing.

Verification (DIM=3, DW=8, MODE=0; centers written (x,y,z))
REQ-037 Reverse order: axis=0, L=(9,0,0), P=(5,0,0), R=(1,0,0) -> outputs (1,..),(5,..),(9,..); left_switch=1, parent_switch=0, right_switch=1; stable=0; swap_count +3; child_axis=1.
REQ-038 Sorted and tie: axis=2, L=(0,0,3), P=(1,1,7), R=(2,2,7) -> outputs equal inputs; stable=1; flags 0; swap_count unchanged; child_axis=0.
REQ-039 Pass-through: sort_en=0 with reverse data -> out_valid 1 edge after accept, outputs equal inputs, stable=1, swap_count unchanged.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs constant, in_ready=0, a second in_valid is ignored; after the handshake, in_ready=1 on the next cycle.
REQ-041 Reset mid-op: rst low in S1 -> immediately IDLE, all outputs 0, swap_count=0, no out_valid pulse.
REQ-042 MODE=1 and saturation: with CNT_W=2, after 4 reverse-order triplets swap_count=3; in MODE=1, L=(0,0,2) vs P=(0,0,1) swaps on the packed value.
